// File: rtl/read_ptr_empty_logic_if.sv
// Read-side FIFO bus: consumer request, write pointer in, read pointer/flags out.
// Defines ALMOST_EMPTY_EN adds almost_empty. master = consumer, slave = logic.
interface read_ptr_empty_logic_if #(
  parameter int address = 2
) ();
  logic               ren;
  logic [address:0]   write_ptr;
  logic [address:0]   read_ptr;
  logic [address-1:0] raddr;
  logic               empty;
  logic               underflow;
`ifdef ALMOST_EMPTY_EN
  logic               almost_empty;
`endif

  modport master (
    output ren,
    output write_ptr,
    input  read_ptr,
    input  raddr,
    input  empty,
    input  underflow
`ifdef ALMOST_EMPTY_EN
    ,
    input  almost_empty
`endif
  );

  modport slave (
    input  ren,
    input  write_ptr,
    output read_ptr,
    output raddr,
    output empty,
    output underflow
`ifdef ALMOST_EMPTY_EN
    ,
    output almost_empty
`endif
  );
endinterface

// File: rtl/read_ptr_empty_logic.sv
// Async FIFO read-side pointer and empty logic (Gray pointers, 2-flop sync).
// Ports: rclk, rreset (sync, active-high), bus (slave). Option: ALMOST_EMPTY_EN.
module read_ptr_empty_logic #(
  parameter int address  = 2,
  parameter int AE_LEVEL = 1
) (
  input logic                    rclk,
  input logic                    rreset,
  read_ptr_empty_logic_if.slave  bus
);
  localparam int AW = address + 1;

  if (AE_LEVEL < 0 || AE_LEVEL > 2**address) begin : g_ae_level_range
    $error("AE_LEVEL out of range");
  end

  logic [AW-1:0] wsync1_q;
  logic [AW-1:0] wsync2_q;
  logic [AW-1:0] rbin_q;
  logic [AW-1:0] rbin_d;
  logic [AW-1:0] rgray_q;
  logic [AW-1:0] rgray_d;
  logic          empty_q;
  logic          empty_d;
  logic          under_q;
  logic          under_d;
  logic          rd_fire;

  always_comb begin
    rd_fire = bus.ren & ~empty_q;
    rbin_d  = rbin_q + {{address{1'b0}}, rd_fire};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    // Wrap bit included: full-lap mismatch is never empty.
    empty_d = (rgray_d == wsync2_q);
    under_d = under_q | (bus.ren & empty_q);
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      wsync1_q <= '0;
      wsync2_q <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      empty_q  <= 1'b1;
      under_q  <= 1'b0;
    end else begin
      wsync1_q <= bus.write_ptr;
      wsync2_q <= wsync1_q;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      empty_q  <= empty_d;
      under_q  <= under_d;
    end
  end

  assign bus.read_ptr  = rgray_q;
  assign bus.raddr     = rbin_q[address-1:0];
  assign bus.empty     = empty_q;
  assign bus.underflow = under_q;

`ifdef ALMOST_EMPTY_EN
  localparam logic [AW-1:0] AE_LVL = AW'(AE_LEVEL);

  logic [AW-1:0] wbin;
  logic [AW-1:0] level;
  logic          ae_q;
  logic          ae_d;

  always_comb begin
    wbin = '0;
    for (int i = 0; i < AW; i++) begin
      wbin[i] = ^(wsync2_q >> i);
    end
    level = wbin - rbin_d;
    ae_d  = (level <= AE_LVL);
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      ae_q <= 1'b1;
    end else begin
      ae_q <= ae_d;
    end
  end

  assign bus.almost_empty = ae_q;
`endif
endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// Directed bench for read_ptr_empty_logic (address=2) with expected-value queue.
// Optional almost_empty checks when ALMOST_EMPTY_EN is defined.
module tb_read_ptr_empty_logic;
  logic rclk;
  logic rreset;

  read_ptr_empty_logic_if #(.address(2)) bus ();

  read_ptr_empty_logic #(.address(2), .AE_LEVEL(1)) dut (
    .rclk   (rclk),
    .rreset (rreset),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [2:0] rp;
    logic [1:0] ra;
    logic       e;
    logic       u;
    logic       ae;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic cyc(input logic rs, input logic rn, input logic [2:0] wp,
                     input logic [2:0] rp, input logic [1:0] ra,
                     input logic e, input logic u, input logic ae = 1'bx);
    exp_t x;
    rreset        = rs;
    bus.ren       = rn;
    bus.write_ptr = wp;
    sb.push_back('{rp: rp, ra: ra, e: e, u: u, ae: ae});
    @(posedge rclk);
    #1;
    x = sb.pop_front();
    chk("read_ptr",  {1'b0, bus.read_ptr},  {1'b0, x.rp});
    chk("raddr",     {2'b0, bus.raddr},     {2'b0, x.ra});
    chk("empty",     {3'b0, bus.empty},     {3'b0, x.e});
    chk("underflow", {3'b0, bus.underflow}, {3'b0, x.u});
`ifdef ALMOST_EMPTY_EN
    if (x.ae !== 1'bx)
      chk("almost_empty", {3'b0, bus.almost_empty}, {3'b0, x.ae});
`endif
  endtask

  initial begin
    rreset        = 1'b1;
    bus.ren       = 1'b0;
    bus.write_ptr = '0;
    #2;
    // reset wins over ren
    cyc(1, 1, 3'b000, 3'b000, 2'b00, 1, 0, 1);
    // one entry: empty drops on third edge, single read empties
    cyc(0, 0, 3'b001, 3'b000, 2'b00, 1, 0);
    cyc(0, 0, 3'b001, 3'b000, 2'b00, 1, 0);
    cyc(0, 0, 3'b001, 3'b000, 2'b00, 0, 0);
    cyc(0, 1, 3'b001, 3'b001, 2'b01, 1, 0);
    // second entry arrives
    cyc(0, 0, 3'b011, 3'b001, 2'b01, 1, 0);
    cyc(0, 0, 3'b011, 3'b001, 2'b01, 1, 0);
    cyc(0, 0, 3'b011, 3'b001, 2'b01, 0, 0);
    // third write lands in the same cycle as a read
    cyc(0, 1, 3'b010, 3'b011, 2'b10, 1, 0);
    cyc(0, 0, 3'b010, 3'b011, 2'b10, 1, 0);
    cyc(0, 0, 3'b010, 3'b011, 2'b10, 0, 0);
    cyc(0, 1, 3'b010, 3'b010, 2'b11, 1, 0);
    // reset mid-stream, then 4 entries
    cyc(1, 0, 3'b110, 3'b000, 2'b00, 1, 0, 1);
    cyc(0, 0, 3'b110, 3'b000, 2'b00, 1, 0);
    cyc(0, 0, 3'b110, 3'b000, 2'b00, 1, 0);
    cyc(0, 0, 3'b110, 3'b000, 2'b00, 0, 0);
    cyc(0, 1, 3'b110, 3'b001, 2'b01, 0, 0);
    cyc(0, 1, 3'b110, 3'b011, 2'b10, 0, 0);
    cyc(0, 1, 3'b110, 3'b010, 2'b11, 0, 0);
    cyc(0, 1, 3'b110, 3'b110, 2'b00, 1, 0);
    // read while empty: pointer holds, underflow sticks
    cyc(0, 1, 3'b110, 3'b110, 2'b00, 1, 1);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 3'b110, 3'b110, 2'b00, 1, 1);
    // second batch of 4 crosses the wrap bit
    cyc(0, 0, 3'b000, 3'b110, 2'b00, 1, 1);
    cyc(0, 0, 3'b000, 3'b110, 2'b00, 1, 1);
    cyc(0, 0, 3'b000, 3'b110, 2'b00, 0, 1);
    cyc(0, 1, 3'b000, 3'b111, 2'b01, 0, 1);
    cyc(0, 1, 3'b000, 3'b101, 2'b10, 0, 1);
    cyc(0, 1, 3'b000, 3'b100, 2'b11, 0, 1);
    cyc(0, 1, 3'b000, 3'b000, 2'b00, 1, 1);
    // only reset clears underflow
    cyc(1, 1, 3'b000, 3'b000, 2'b00, 1, 0, 1);
    // two entries: almost_empty tracking
    cyc(0, 0, 3'b011, 3'b000, 2'b00, 1, 0, 1);
    cyc(0, 0, 3'b011, 3'b000, 2'b00, 1, 0, 1);
    cyc(0, 0, 3'b011, 3'b000, 2'b00, 0, 0, 0);
    cyc(0, 1, 3'b011, 3'b001, 2'b01, 0, 0, 1);
    cyc(0, 1, 3'b011, 3'b011, 2'b10, 1, 0, 1);
    cyc(0, 0, 3'b011, 3'b011, 2'b10, 1, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
